seq_shift_unit: RTL and testbench

Iterative multi-cycle shifter in the R-type execute stage. Produces the shift result that feeds one data input of the 32-bit 4:1 result-select mux.
- Accepts one operation per start pulse.
- Shifts one bit position per clock (four with the optional feature).
- Presents a registered result with a one-cycle done pulse, so the control unit can stall until the result is valid.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_step.sv | 34 +++
 rtl/seq_shift_unit.sv | 104 ++++++++++
 tb/tb_seq_shift_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: op codes and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 1 or 4 positions for SLL/SRL/SRA/ROR.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] work,
    input  logic [1:0]       op,
    input  logic             step4,
    output logic [WIDTH-1:0] next_work
);

    always_comb begin
        next_work = work;
        if (step4) begin
            unique case (op)
                OP_SLL: next_work = {work[WIDTH-5:0], 4'b0000};
                OP_SRL: next_work = {4'b0000, work[WIDTH-1:4]};
                OP_SRA: next_work = {{4{work[WIDTH-1]}}, work[WIDTH-1:4]};
                OP_ROR: next_work = {work[3:0], work[WIDTH-1:4]};
                default: next_work = work;
            endcase
        end else begin
            unique case (op)
                OP_SLL: next_work = {work[WIDTH-2:0], 1'b0};
                OP_SRL: next_work = {1'b0, work[WIDTH-1:1]};
                OP_SRA: next_work = {work[WIDTH-1], work[WIDTH-1:1]};
                OP_ROR: next_work = {work[0], work[WIDTH-1:1]};
                default: next_work = work;
            endcase
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative multi-cycle shifter with registered result and one-cycle done pulse.
// Define SEQ_SHIFT_FAST_EN to step four positions per cycle while cnt >= 4.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   next_work;
    logic               step4;
    logic [SHAMT_W-1:0] step_amt;

`ifdef SEQ_SHIFT_FAST_EN
    assign step4 = (cnt_q >= SHAMT_W'(4));
`else
    assign step4 = 1'b0;
`endif
    assign step_amt = step4 ? SHAMT_W'(4) : SHAMT_W'(1);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_shift_step (
        .work     (work_q),
        .op       (op_q),
        .step4    (step4),
        .next_work(next_work)
    );

    // result is loaded on entry to FINISH so it is already valid while done is high
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = a;
                    op_d   = op;
                    cnt_d  = shamt;
                    if (shamt == '0) begin
                        state_d  = FINISH;
                        result_d = a;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy   = 1'b1;
                work_d = next_work;
                cnt_d  = cnt_q - step_amt;
                if (cnt_q == step_amt) begin
                    state_d  = FINISH;
                    result_d = next_work;
                end
            end
            FINISH: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= OP_SLL;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit (default and SEQ_SHIFT_FAST_EN builds).
module tb_seq_shift_unit;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    seq_shift_unit #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int s);
`ifdef SEQ_SHIFT_FAST_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Issue one op, scramble inputs after the latch edge, then wait (bounded) for done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                          input logic [4:0] s, input logic [31:0] exp);
        int lat;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = v;
        shamt = s;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'($urandom);
        a       = $urandom;
        shamt   = 5'($urandom);
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat(int'(s))));
        check({tag, ".result"}, result, exp);
        check({tag, ".busy_during"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int lat;
        logic [31:0] res;

        reset = 1'b0;
        start = 1'b1;
        op    = OP_SLL;
        a     = 32'hFFFF_FFFF;
        shamt = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", result, 32'h0);
        start = 1'b0;
        reset = 1'b1;

        run_op("sll4", OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010);
        run_op("sra31", OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("ror4", OP_ROR, 32'h0000_00F1, 5'd4, 32'h1000_000F);
        run_op("srl0", OP_SRL, 32'hF000_0000, 5'd0, 32'hF000_0000);
        run_op("sra1", OP_SRA, 32'h8000_0000, 5'd1, 32'hC000_0000);
        run_op("sra_pos", OP_SRA, 32'h7000_0000, 5'd4, 32'h0700_0000);
        run_op("ror31", OP_ROR, 32'h0000_0001, 5'd31, 32'h0000_0002);
        run_op("sll31", OP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);
        run_op("srl5", OP_SRL, 32'h8000_0000, 5'd5, 32'h0400_0000);
        run_op("sll7", OP_SLL, 32'h0000_0003, 5'd7, 32'h0000_0180);

        // start pulsed while busy must be ignored
        @(negedge clk);
        start  = 1'b1;
        op     = OP_SLL;
        a      = 32'h1234_5678;
        shamt  = 5'd8;
        pulses = 0;
        lat    = 0;
        res    = 32'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start = 1'b1;
                a     = 32'hFFFF_FFFF;
                op    = OP_SRL;
                shamt = 5'd1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                res = result;
                lat = i;
            end
        end
        check("ignore.pulses", 32'(pulses), 32'd1);
        check("ignore.result", res, 32'h3456_7800);
        check("ignore.latency", 32'(lat), 32'(exp_lat(8)));

        // reset mid-operation aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        op    = OP_SRL;
        a     = 32'hFFFF_0000;
        shamt = 5'd16;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", result, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort.pulses", 32'(pulses), 32'd0);
        check("abort.result_hold", result, 32'h0);

        run_op("post_reset", OP_SRL, 32'hFFFF_0000, 5'd16, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hung expected finish");
        $fatal(1, "timeout");
    end

endmodule
